// File: rtl/ternary_neuron_accumulator.sv
// Ternary neuron accumulator: sums signed (pos_cnt - neg_cnt) differences
// over a multi-beat evaluation with saturation, then thresholds the final
// sum into a ternary activation presented through a valid/ready handshake.
module ternary_neuron_accumulator #(
  parameter int unsigned ACC_W = 10,
  parameter int signed   T_HI  = 3,
  parameter int signed   T_LO  = -3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [3:0]              pos_cnt,
  input  logic [3:0]              neg_cnt,
  input  logic                    in_last,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [1:0]              out_act,
  output logic signed [ACC_W-1:0] out_acc,
  output logic                    out_sat
);

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  state_t                  state;
  logic signed [ACC_W-1:0] acc;
  logic                    sat_flag;

  logic signed [4:0]       diff;
  logic signed [ACC_W:0]   sum_wide;
  logic signed [ACC_W-1:0] nxt;
  logic                    nxt_sat;
  logic [1:0]              nxt_act;
  logic                    beat_fire;

  // Handshake flags decode only the registered state.
  assign in_ready  = (state == ACCUM);
  assign out_valid = (state == HOLD);
  assign beat_fire = in_valid && in_ready;

  // Beat difference, widened sum and saturation, plus threshold decision.
  always_comb begin
    diff     = $signed({1'b0, pos_cnt}) - $signed({1'b0, neg_cnt});
    sum_wide = {acc[ACC_W-1], acc} + {{(ACC_W-4){diff[4]}}, diff};
    nxt      = sum_wide[ACC_W-1:0];
    nxt_sat  = 1'b0;
    if (sum_wide[ACC_W] != sum_wide[ACC_W-1]) begin
      nxt_sat = 1'b1;
      nxt     = sum_wide[ACC_W] ? ACC_MIN : ACC_MAX;
    end
    nxt_act = 2'b00;
    if (nxt > T_HI)
      nxt_act = 2'b01;
    else if (nxt < T_LO)
      nxt_act = 2'b11;
  end

  // Evaluation FSM with registered result outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ACCUM;
      acc      <= '0;
      sat_flag <= 1'b0;
      out_act  <= 2'b00;
      out_acc  <= '0;
      out_sat  <= 1'b0;
    end else begin
      case (state)
        ACCUM: begin
          if (beat_fire) begin
            if (in_last) begin
              out_acc  <= nxt;
              out_act  <= nxt_act;
              out_sat  <= sat_flag | nxt_sat;
              acc      <= '0;
              sat_flag <= 1'b0;
              state    <= HOLD;
            end else begin
              acc      <= nxt;
              sat_flag <= sat_flag | nxt_sat;
            end
          end
        end
        HOLD: begin
          if (out_ready)
            state <= ACCUM;
        end
        default: state <= ACCUM;
      endcase
    end
  end

endmodule

// File: tb/tb_ternary_neuron_accumulator.sv
// Directed self-checking bench for ternary_neuron_accumulator.
module tb_ternary_neuron_accumulator;

  localparam int ACC_W = 10;

  logic                    clk = 1'b0;
  logic                    rst = 1'b1;
  logic                    in_valid = 1'b0;
  logic                    in_ready;
  logic [3:0]              pos_cnt = '0;
  logic [3:0]              neg_cnt = '0;
  logic                    in_last = 1'b0;
  logic                    out_valid;
  logic                    out_ready = 1'b1;
  logic [1:0]              out_act;
  logic signed [ACC_W-1:0] out_acc;
  logic                    out_sat;

  int tests  = 0;
  int failed = 0;

  ternary_neuron_accumulator #(.ACC_W(ACC_W), .T_HI(3), .T_LO(-3)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .pos_cnt(pos_cnt), .neg_cnt(neg_cnt), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_act(out_act), .out_acc(out_acc), .out_sat(out_sat)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one beat and hold it until accepted (bounded wait).
  task automatic send_beat(input logic [3:0] p, input logic [3:0] n, input logic last);
    int waited = 0;
    in_valid = 1'b1;
    pos_cnt  = p;
    neg_cnt  = n;
    in_last  = last;
    while (!in_ready && waited < 50) begin
      tick();
      waited++;
    end
    tests++;
    if (!in_ready) begin
      failed++;
      $display("FAIL beat_accept_timeout: in_ready=%0b required 1", in_ready);
    end
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Called #1 after the last-beat edge with out_ready=1: check result, then
  // confirm out_valid lasts exactly one cycle.
  task automatic check_result(input string name, input int exp_acc,
                              input logic [1:0] exp_act, input logic exp_sat);
    tests++;
    if (out_valid !== 1'b1) begin
      failed++;
      $display("FAIL %s_valid: out_valid=%0b required 1", name, out_valid);
    end
    tests++;
    if (out_acc !== exp_acc[ACC_W-1:0]) begin
      failed++;
      $display("FAIL %s_acc: out_acc=%0d required %0d", name, out_acc, exp_acc);
    end
    tests++;
    if (out_act !== exp_act) begin
      failed++;
      $display("FAIL %s_act: out_act=%b required %b", name, out_act, exp_act);
    end
    tests++;
    if (out_sat !== exp_sat) begin
      failed++;
      $display("FAIL %s_sat: out_sat=%0b required %0b", name, out_sat, exp_sat);
    end
    tick();
    tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failed++;
      $display("FAIL %s_drop: out_valid=%0b in_ready=%0b required 0/1", name, out_valid, in_ready);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_act !== 2'b00 ||
        out_acc !== '0 || out_sat !== 1'b0) begin
      failed++;
      $display("FAIL reset_state: valid=%0b ready=%0b act=%b acc=%0d sat=%0b required 0 1 00 0 0",
               out_valid, in_ready, out_act, out_acc, out_sat);
    end
  endtask

  task automatic test_basic();
    out_ready = 1'b1;
    send_beat(4'd5, 4'd1, 1'b0);
    send_beat(4'd4, 4'd2, 1'b0);
    tests++;
    if (out_valid !== 1'b0) begin
      failed++;
      $display("FAIL basic_early_valid: out_valid=%0b required 0", out_valid);
    end
    send_beat(4'd3, 4'd0, 1'b1);
    check_result("basic", 9, 2'b01, 1'b0);
  endtask

  task automatic test_negative_zero();
    send_beat(4'd0, 4'd7, 1'b0);
    send_beat(4'd2, 4'd3, 1'b1);
    check_result("neg8", -8, 2'b11, 1'b0);
    send_beat(4'd4, 4'd1, 1'b1);
    check_result("eq_thi", 3, 2'b00, 1'b0);
    send_beat(4'd1, 4'd5, 1'b1);
    check_result("neg4", -4, 2'b11, 1'b0);
    send_beat(4'd0, 4'd3, 1'b1);
    check_result("eq_tlo", -3, 2'b00, 1'b0);
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    send_beat(4'd9, 4'd0, 1'b1);
    // Producer holds a new beat while the output is stalled.
    in_valid = 1'b1;
    pos_cnt  = 4'd2;
    neg_cnt  = 4'd0;
    in_last  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tests++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_acc !== 10'sd9 ||
          out_act !== 2'b01 || out_sat !== 1'b0) begin
        failed++;
        $display("FAIL bp_hold[%0d]: valid=%0b ready=%0b acc=%0d act=%b sat=%0b required 1 0 9 01 0",
                 i, out_valid, in_ready, out_acc, out_act, out_sat);
      end
      tick();
    end
    out_ready = 1'b1;
    tick();
    tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failed++;
      $display("FAIL bp_release: valid=%0b ready=%0b required 0 1", out_valid, in_ready);
    end
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
    check_result("bp_held_beat", 2, 2'b00, 1'b0);
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 40; i++)
      send_beat(4'd15, 4'd0, (i == 39));
    check_result("sat_pos", 511, 2'b01, 1'b1);
    send_beat(4'd0, 4'd0, 1'b1);
    check_result("sat_clear", 0, 2'b00, 1'b0);
    for (int i = 0; i < 40; i++)
      send_beat(4'd0, 4'd15, (i == 39));
    check_result("sat_neg", -512, 2'b11, 1'b1);
    send_beat(4'd11, 4'd0, 1'b1);
    check_result("overshoot", 11, 2'b01, 1'b0);
  endtask

  task automatic test_reset_mid();
    send_beat(4'd5, 4'd0, 1'b0);
    send_beat(4'd5, 4'd0, 1'b0);
    rst = 1'b1;
    tick();
    tests++;
    if (out_valid !== 1'b0) begin
      failed++;
      $display("FAIL rst_mid_during: out_valid=%0b required 0", out_valid);
    end
    rst = 1'b0;
    send_beat(4'd1, 4'd0, 1'b1);
    check_result("rst_mid", 1, 2'b00, 1'b0);
    // Reset while holding a pending result.
    out_ready = 1'b0;
    send_beat(4'd7, 4'd0, 1'b1);
    tests++;
    if (out_valid !== 1'b1) begin
      failed++;
      $display("FAIL rst_hold_pre: out_valid=%0b required 1", out_valid);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failed++;
      $display("FAIL rst_hold: valid=%0b ready=%0b required 0 1", out_valid, in_ready);
    end
    out_ready = 1'b1;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_negative_zero();
    test_backpressure();
    test_saturation();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/ternary_neuron_accumulator.md
Name: ternary_neuron_accumulator

Overview:
- Sequential stage directly downstream of the 10-input approximate popcount units in the printed ternary-neuron datapath.
- Each beat takes two 4-bit popcounts: matches on +1 weights and matches on -1 weights. It accumulates their signed difference over a multi-beat neuron evaluation.
- On the last beat it applies two thresholds and emits a ternary activation (-1/0/+1) through a valid/ready handshake.

Parameters:
- ACC_W, 10, signed accumulator width in bits (two's complement, saturating).
- T_HI, 3, signed threshold; acc > T_HI gives activation +1.
- T_LO, -3, signed threshold; acc < T_LO gives activation -1. Legal only when T_LO <= T_HI.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous reset, active-high
- in_valid  in  1  input beat valid
- in_ready  out  1  stage can accept a beat
- pos_cnt  in  4  popcount of +1-weight lanes; raw approximate value 0..15 accepted, no clamp
- neg_cnt  in  4  popcount of -1-weight lanes; same range as pos_cnt
- in_last  in  1  final beat of this neuron evaluation
- out_valid  out  1  activation valid
- out_ready  in  1  consumer accepts activation
- out_act  out  2  ternary activation: 2'b01 = +1, 2'b00 = 0, 2'b11 = -1 (2'b10 never driven)
- out_acc  out  ACC_W  final saturated accumulator value (signed), for debug and verification
- out_sat  out  1  saturation occurred at any beat of this evaluation

Behaviour:
- Reset (synchronous, rst=1 at a clk edge):
  - State goes to ACCUM.
  - acc=0, sat flag=0.
  - out_valid=0, out_act=2'b00, out_acc=0, out_sat=0.
  - in_ready=1 from the first cycle after reset deasserts.
  - Reset mid-evaluation discards all partial sums and any pending output.
- States: ACCUM and HOLD.
- ACCUM:
  - in_ready=1 and out_valid=0.
  - Beat accepted when in_valid && in_ready.
  - On each accepted beat: d = zero-extend(pos_cnt) - zero-extend(neg_cnt), range -15..+15.
  - nxt = acc + d, computed at ACC_W+1 bits and saturated to [-2^(ACC_W-1), 2^(ACC_W-1)-1].
  - If saturation occurs, the sat flag is set and stays sticky until the evaluation ends.
- Accepted beat with in_last=0: acc <= nxt; stay in ACCUM.
- Accepted beat with in_last=1:
  - Result = nxt. Set out_acc=nxt, out_sat = sticky flag OR saturation on this beat.
  - out_act = +1 if nxt > T_HI; -1 if nxt < T_LO; else 0. Signed compares; equality gives 0.
  - Next state HOLD. acc and sat flag clear to 0.
  - Latency: out_valid rises in the cycle after the last-beat handshake.
- Single-beat evaluation (in_last=1 on the first beat) is legal; result is d alone.
- HOLD:
  - in_ready=0, out_valid=1.
  - out_act, out_acc and out_sat stay stable until the handshake; this is required even if out_ready stays low indefinitely.
  - On out_valid && out_ready: out_valid drops next cycle and state returns to ACCUM.
  - Output registers keep their last values but are don't-care while out_valid=0.
- No bypass: a new evaluation's first beat can be accepted at the earliest in the cycle after the output handshake.
  - Throughput is therefore one evaluation per (beats + 1) cycles when out_ready is held high.
- in_valid while in_ready=0 is ignored; the producer must hold the beat.
- pos_cnt, neg_cnt and in_last are sampled only on an accepted beat.
- in_ready and out_valid depend only on the registered state. No combinational path exists from in_valid or out_ready to in_ready or out_valid.

Test Plan:
- Basic +1: reset, then three beats (pos,neg) = (5,1), (4,2), (3,0), last on the third, out_ready=1 -> acc=9, out_act=01, out_sat=0. out_valid is high exactly one cycle, the cycle after the third beat.
- Negative and zero: beats (0,7), (2,3) with last -> acc=-8, out_act=11. Then a single beat (4,1) with last -> acc=3, out_act=00 (equal to T_HI gives 0). Then (1,5) with last -> acc=-4, out_act=11.
- Backpressure: complete an evaluation ending at acc=9 with out_ready=0 for 5 cycles -> out_valid held and outputs stable, in_ready=0. Drive a beat with in_valid=1 during this time -> it is not consumed. Raise out_ready -> handshake; the held beat is accepted in the next ACCUM cycle.
- Saturation: ACC_W=10; 40 beats of (15,0) with last on the 40th -> acc=511, out_sat=1, out_act=01. The next evaluation, a single beat (0,0) with last -> acc=0, out_sat=0 (flag cleared).
- Negative saturation plus out-of-range counts: ACC_W=10; 40 beats of (0,15) -> acc=-512, out_sat=1. A beat with pos_cnt=11 (approximate overshoot) is accumulated unclamped: single beat (11,0) with last -> acc=11.
- Reset mid-operation: after two beats of (5,0), assert rst for one cycle, then a single beat (1,0) with last -> acc=1, out_act=00, out_valid=0 during and immediately after reset. Also assert rst while in HOLD -> out_valid=0 the next cycle.
